// File: rtl/alu_arbiter_ctrl.sv
// Two-master round-robin sequencer in front of a shared ALU; one operation in flight.
// Optional WAIT-state timeout is compiled in with `define ALU_ARB_TIMEOUT_EN.
module alu_arbiter_ctrl #(
  parameter int M       = 4,
  parameter int TIMEOUT = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req,
  input  logic [2:0]     req0_op,
  input  logic [M-1:0]   req0_a,
  input  logic [M-1:0]   req0_b,
  input  logic [2:0]     req1_op,
  input  logic [M-1:0]   req1_a,
  input  logic [M-1:0]   req1_b,
  output logic [1:0]     ack,
  output logic           alu_init,
  output logic [2:0]     alu_opcode,
  output logic [M-1:0]   alu_a,
  output logic [M-1:0]   alu_b,
  input  logic [2*M-1:0] alu_y,
  input  logic           alu_overflow,
  input  logic           alu_zero,
  input  logic           alu_done,
  output logic [1:0]     rsp_valid,
  output logic [2*M-1:0] rsp_y,
  output logic           rsp_ovf,
  output logic           rsp_zero,
  output logic           rsp_err,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t       state;
  logic         rr_ptr;
  logic         owner;
  logic         win;
  logic [2:0]   sel_op;
  logic [M-1:0] sel_a;
  logic [M-1:0] sel_b;

  if (TIMEOUT < 1) begin : g_timeout_range
    $error("alu_arbiter_ctrl: TIMEOUT must be at least 1");
  end

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
`endif

  always_comb begin
    win    = (req == 2'b11) ? rr_ptr : req[1];
    sel_op = win ? req1_op : req0_op;
    sel_a  = win ? req1_a  : req0_a;
    sel_b  = win ? req1_b  : req0_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      ack        <= '0;
      alu_init   <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= '0;
      rsp_y      <= '0;
      rsp_ovf    <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      ack       <= '0;
      alu_init  <= 1'b0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            owner      <= win;
            ack        <= win ? 2'b10 : 2'b01;
            alu_opcode <= sel_op;
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            busy       <= 1'b1;
            if (sel_op > 3'd4) begin
              rsp_y    <= '0;
              rsp_ovf  <= 1'b0;
              rsp_zero <= 1'b0;
              rsp_err  <= 1'b1;
              state    <= RESP;
            end else begin
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          alu_init <= 1'b1;
          state    <= WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (alu_done) begin
            rsp_y     <= alu_y;
            rsp_ovf   <= alu_overflow;
            rsp_zero  <= alu_zero;
            rsp_err   <= 1'b0;
            rsp_valid <= owner ? 2'b10 : 2'b01;
            state     <= RESP;
          end
`ifdef ALU_ARB_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            rsp_y     <= '0;
            rsp_ovf   <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_valid <= owner ? 2'b10 : 2'b01;
            state     <= RESP;
          end else begin
            wait_cnt  <= wait_cnt + CW'(1);
          end
`endif
        end
        RESP: begin
          // ALU completions pulse rsp_valid on the way into RESP; the
          // illegal-opcode path reaches RESP straight from IDLE and pulses here.
          if (rsp_valid == '0) rsp_valid <= owner ? 2'b10 : 2'b01;
          rr_ptr <= ~owner;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Bench for alu_arbiter_ctrl: directed vector table, corner sequences and a
// randomized two-master run checked by a transaction-level scoreboard.
module tb_alu_arbiter_ctrl;
  localparam int M         = 4;
  localparam int MUL_EXTRA = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req;
  logic       rq0 = 1'b0, rq1 = 1'b0;
  logic [2:0] r0_op = '0, r1_op = '0;
  logic [3:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
  logic [1:0] ack, rsp_valid;
  logic       alu_init, rsp_ovf, rsp_zero, rsp_err, busy;
  logic [2:0] alu_opcode;
  logic [3:0] alu_a, alu_b;
  logic [7:0] alu_y = '0, rsp_y;
  logic       alu_overflow = 1'b0, alu_zero = 1'b0, alu_done = 1'b0;

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b1;
  logic mute   = 1'b0;

  assign req = {rq1, rq0};

  always #5 clk = ~clk;

  alu_arbiter_ctrl #(.M(M), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req0_op(r0_op), .req0_a(r0_a), .req0_b(r0_b),
    .req1_op(r1_op), .req1_a(r1_a), .req1_b(r1_b),
    .ack(ack), .alu_init(alu_init), .alu_opcode(alu_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_ovf(rsp_ovf),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU: {overflow, zero, y}; overflow is signed M-bit overflow for ADD/SUB.
  function automatic logic [9:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] s;
    logic [7:0] y;
    logic       v;
    s = '0; y = '0; v = 1'b0;
    case (op)
      3'd0: begin s = a + b; y = 8'(a) + 8'(b); v = (a[3] == b[3]) && (s[3] != a[3]); end
      3'd1: begin s = a - b; y = {4'h0, s};     v = (a[3] != b[3]) && (s[3] != a[3]); end
      3'd2: y = {4'h0, a ^ b};
      3'd3: y = 8'(a) << b[2:0];
      3'd4: y = 8'(a) * 8'(b);
      default: ;
    endcase
    return {v, (y == 8'h00), y};
  endfunction

  function automatic logic [31:0] all_outs();
    return {4'h0, ack, rsp_valid, alu_init, alu_opcode, alu_a, alu_b,
            rsp_y, rsp_ovf, rsp_zero, rsp_err, busy};
  endfunction

  // Behavioural ALU: done one cycle after init, MUL_EXTRA more for MUL; y is noise otherwise.
  logic       alu_act = 1'b0;
  int         acnt = 0;
  logic [2:0] c_op = '0;
  logic [3:0] c_a = '0, c_b = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_done <= 1'b0;
      alu_act  <= 1'b0;
      acnt     <= 0;
    end else begin
      alu_done     <= 1'b0;
      alu_y        <= 8'($urandom);
      alu_overflow <= 1'($urandom);
      alu_zero     <= 1'($urandom);
      if (alu_init && !alu_act) begin
        c_op <= alu_opcode; c_a <= alu_a; c_b <= alu_b;
        if (alu_opcode == 3'd4 || mute) begin
          alu_act <= 1'b1;
          acnt    <= MUL_EXTRA - 1;
        end else begin
          alu_done <= 1'b1;
          {alu_overflow, alu_zero, alu_y} <= alu_fn(alu_opcode, alu_a, alu_b);
        end
      end else if (alu_act && !mute) begin
        if (acnt == 0) begin
          alu_done <= 1'b1;
          alu_act  <= 1'b0;
          {alu_overflow, alu_zero, alu_y} <= alu_fn(c_op, c_a, c_b);
        end else begin
          acnt <= acnt - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && alu_act)
      chk("alu_hold", {21'h0, alu_opcode, alu_a, alu_b}, {21'h0, c_op, c_a, c_b});
  end

  // Transaction scoreboard: predicts winner, latency, response and hold behaviour.
  logic       prev_busy = 1'b0, rr_m = 1'b0, pending = 1'b0;
  logic [1:0] prev_req = '0;
  logic [2:0] prev_op0 = '0, prev_op1 = '0;
  logic [3:0] prev_a0 = '0, prev_b0 = '0, prev_a1 = '0, prev_b1 = '0;
  logic       p_owner = 1'b0, p_err = 1'b0, p_ovf = 1'b0, p_zero = 1'b0;
  logic [7:0] p_y = '0;
  logic [2:0] p_op = '0;
  logic [3:0] p_a = '0, p_b = '0;
  int         p_lat = 0, p_exp_lat = 0;
  logic [10:0] last_rsp = '0;

  always @(negedge clk) begin : mon
    logic       w, was_pending;
    logic [1:0] exp_ack, exp_rv;
    if (!rst) begin
      pending = 1'b0; prev_busy = 1'b0; prev_req = '0; rr_m = 1'b0; last_rsp = '0;
    end else if (mon_en) begin
      was_pending = pending;
      exp_ack = '0;
      exp_rv  = '0;
      if (!prev_busy && prev_req != 2'b00) begin
        w = (prev_req == 2'b11) ? rr_m : prev_req[1];
        exp_ack = w ? 2'b10 : 2'b01;
        p_owner = w;
        p_op = w ? prev_op1 : prev_op0;
        p_a  = w ? prev_a1  : prev_a0;
        p_b  = w ? prev_b1  : prev_b0;
        p_err = (p_op > 3'd4);
        if (p_err) {p_ovf, p_zero, p_y} = '0;
        else       {p_ovf, p_zero, p_y} = alu_fn(p_op, p_a, p_b);
        p_exp_lat = p_err ? 1 : (p_op == 3'd4 ? 3 + MUL_EXTRA : 3);
        if (pending) chk("overlap", 32'd1, 32'd0);
        pending = 1'b1;
        p_lat = 0;
        chk("latch_ops", {21'h0, alu_opcode, alu_a, alu_b}, {21'h0, p_op, p_a, p_b});
      end else if (pending) begin
        p_lat++;
      end
      chk("ack", 32'(ack), 32'(exp_ack));
      chk("alu_init", 32'(alu_init), 32'(pending && !p_err && p_lat == 1));
      chk("busy", 32'(busy), 32'(pending && (p_err ? p_lat == 0 : 1'b1)));
      if (pending && p_lat == p_exp_lat) exp_rv = p_owner ? 2'b10 : 2'b01;
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv != 2'b00) begin
        chk("rsp_data", {21'h0, rsp_err, rsp_ovf, rsp_zero, rsp_y}, {21'h0, p_err, p_ovf, p_zero, p_y});
        last_rsp = {p_err, p_ovf, p_zero, p_y};
        rr_m = ~p_owner;
        pending = 1'b0;
      end else if (!was_pending && exp_ack == 2'b00) begin
        chk("rsp_hold", {21'h0, rsp_err, rsp_ovf, rsp_zero, rsp_y}, {21'h0, last_rsp});
      end
    end
    prev_busy = busy; prev_req = req;
    prev_op0 = r0_op; prev_a0 = r0_a; prev_b0 = r0_b;
    prev_op1 = r1_op; prev_a1 = r1_a; prev_b1 = r1_b;
  end

  task automatic drive(input logic m, input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    if (m) begin rq1 = v; if (v) begin r1_op = op; r1_a = a; r1_b = b; end end
    else   begin rq0 = v; if (v) begin r0_op = op; r0_a = a; r0_b = b; end end
  endtask

  task automatic wait_ack(input logic m, input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (ack[m]) got = 1'b1;
    end
    chk(name, 32'(got), 32'd1);
  endtask

  task automatic do_op(input logic m, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       output logic [10:0] r, output logic [1:0] rv, output int lat);
    @(posedge clk); #1;
    drive(m, 1'b1, op, a, b);
    wait_ack(m, "op_ack_seen");
    @(posedge clk); #1;
    drive(m, 1'b0, op, a, b);
    lat = 0; rv = '0; r = '0;
    for (int i = 0; i < 40 && rv == 2'b00; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid != 2'b00) begin rv = rsp_valid; r = {rsp_err, rsp_ovf, rsp_zero, rsp_y}; end
    end
  endtask

  task automatic pair(input logic [2:0] op0, input logic [3:0] a0, input logic [3:0] b0,
                      input logic [2:0] op1, input logic [3:0] a1, input logic [3:0] b1,
                      output logic [1:0] first, output logic [1:0] second,
                      output logic [8:0] d0, output logic [8:0] d1);
    int n;
    logic [1:0] acked;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, op0, a0, b0);
    drive(1'b1, 1'b1, op1, a1, b1);
    n = 0; first = '0; second = '0; d0 = '0; d1 = '0;
    for (int i = 0; i < 60 && n < 2; i++) begin
      @(negedge clk);
      acked = ack;
      if (rsp_valid != 2'b00) begin
        if (n == 0) begin first = rsp_valid; d0 = {rsp_zero, rsp_y}; end
        else        begin second = rsp_valid; d1 = {rsp_zero, rsp_y}; end
        n++;
      end
      @(posedge clk); #1;
      if (acked[0]) rq0 = 1'b0;
      if (acked[1]) rq1 = 1'b0;
    end
  endtask

  typedef struct {
    logic       m;
    logic [2:0] op;
    logic [3:0] a, b;
    logic [7:0] y;
    logic       ovf, zero, err;
    int         lat;
  } vec_t;

  vec_t       tbl[7];
  logic [10:0] r;
  logic [1:0]  rv, f, s;
  logic [8:0]  d0, d1;
  int          lat;
  logic        stuck;

  initial begin
    tbl[0] = '{1'b0, 3'd0, 4'h3, 4'h5, 8'h08, 1'b1, 1'b0, 1'b0, 3};
    tbl[1] = '{1'b1, 3'd4, 4'hF, 4'hF, 8'hE1, 1'b0, 1'b0, 1'b0, 3 + MUL_EXTRA};
    tbl[2] = '{1'b0, 3'd6, 4'h1, 4'h2, 8'h00, 1'b0, 1'b0, 1'b1, 1};
    tbl[3] = '{1'b1, 3'd1, 4'h5, 4'h7, 8'h0E, 1'b0, 1'b0, 1'b0, 3};
    tbl[4] = '{1'b0, 3'd2, 4'hA, 4'hA, 8'h00, 1'b0, 1'b1, 1'b0, 3};
    tbl[5] = '{1'b1, 3'd3, 4'h3, 4'h2, 8'h0C, 1'b0, 1'b0, 1'b0, 3};
    tbl[6] = '{1'b1, 3'd7, 4'h4, 4'h4, 8'h00, 1'b0, 1'b0, 1'b1, 1};

    #12;
    chk("reset_outputs", all_outs(), 32'h0);
    @(posedge clk); #3;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    pair(3'd1, 4'h2, 4'h2, 3'd2, 4'hF, 4'h0, f, s, d0, d1);
    chk("pair1_first", 32'(f), 32'h1);
    chk("pair1_first_data", 32'(d0), {23'h0, 1'b1, 8'h00});
    chk("pair1_second", 32'(s), 32'h2);
    chk("pair1_second_data", 32'(d1), {23'h0, 1'b0, 8'h0F});
    pair(3'd0, 4'h1, 4'h2, 3'd0, 4'h4, 4'h4, f, s, d0, d1);
    chk("pair2_first", 32'(f), 32'h1);
    chk("pair2_second_data", 32'(d1), {23'h0, 1'b0, 8'h08});

    for (int unsigned i = 0; i < 7; i++) begin
      do_op(tbl[i].m, tbl[i].op, tbl[i].a, tbl[i].b, r, rv, lat);
      chk($sformatf("vec%0d_owner", i), 32'(rv), tbl[i].m ? 32'h2 : 32'h1);
      chk($sformatf("vec%0d_data", i), 32'(r), {21'h0, tbl[i].err, tbl[i].ovf, tbl[i].zero, tbl[i].y});
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
    end

    // Reset in WAIT: outputs clear without a clock edge, old response never appears.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 3'd4, 4'h3, 4'h3);
    wait_ack(1'b1, "rst_ack_seen");
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 3'd4, 4'h3, 4'h3);
    @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", all_outs(), 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    stuck = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid != 2'b00 || busy) stuck = 1'b1;
    end
    chk("no_stale_response", 32'(stuck), 32'd0);
    do_op(1'b0, 3'd0, 4'h1, 4'h1, r, rv, lat);
    chk("post_reset_add", {19'h0, rv, r}, {19'h0, 2'b01, 11'h002});

    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          @(posedge clk); #1;
          drive(1'b0, 1'b1, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
          wait_ack(1'b0, "rand_ack0");
          @(posedge clk); #1;
          rq0 = 1'b0;
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          @(posedge clk); #1;
          drive(1'b1, 1'b1, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
          wait_ack(1'b1, "rand_ack1");
          @(posedge clk); #1;
          rq1 = 1'b0;
        end
      end
    join
    repeat (12) @(posedge clk);

    mon_en = 1'b0;
    mute   = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 3'd0, 4'h2, 4'h3);
    wait_ack(1'b0, "hang_ack_seen");
    @(posedge clk); #1;
    rq0 = 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
    lat = 0; rv = '0; r = '0;
    for (int i = 0; i < 60 && rv == 2'b00; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid != 2'b00) begin rv = rsp_valid; r = {rsp_err, rsp_ovf, rsp_zero, rsp_y}; end
    end
    chk("timeout_latency", 32'(lat), 32'd33);
    chk("timeout_rsp", {19'h0, rv, r}, {19'h0, 2'b01, 11'h400});
`else
    stuck = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (!busy || rsp_valid != 2'b00) stuck = 1'b0;
    end
    chk("busy_without_done", 32'(stuck), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
